// File: rtl/decode_hazard_scoreboard_pkg.sv
// Shared constants and FSM encoding for the decode hazard scoreboard.
package decode_hazard_scoreboard_pkg;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned CNT_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_e;

endpackage

// File: rtl/decode_hazard_scoreboard_counter.sv
// Single scoreboard entry: load on issue, otherwise count down and stick at zero.
module decode_hazard_scoreboard_counter
    import decode_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement so a WAW reissue restarts the countdown.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage issue control: per-register countdown scoreboard, special-unit
// occupancy, drain FSM and stall performance counter.
module decode_hazard_scoreboard
    import decode_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned WB_LATENCY  = 5,
    parameter int unsigned SPECIAL_LAT = 4,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ID_valid,
    input  logic        ID_flush,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_WriteRegister,
    input  logic        ID_special,
    input  logic        drain_req,
    output logic        ID_stall,
    output logic        ID_issue,
    output logic [31:0] busy_mask,
    output logic        special_busy,
    output logic        drained,
    output logic [15:0] stall_count
);

    state_e            r_state;
    logic              r_drained;
    logic [15:0]       r_stall_count;

    logic [CNT_W-1:0]  w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [CNT_W-1:0]  w_special_cnt;
    logic              w_special_busy;
    logic              w_raw_a;
    logic              w_raw_b;
    logic              w_sp_haz;
    logic              w_live;
    logic              w_issue;
    logic              w_stall;
    logic              w_wr_load;
    logic              w_sp_load;
    logic              w_all_idle;

    // A count of 1 means the write lands this cycle and the WB bypass covers it.
    always_comb begin
        w_raw_a   = ID_uses_rs & (ID_rs != REG_ZERO) & (w_cnt[ID_rs] > CNT_W'(1));
        w_raw_b   = ID_uses_rt & (ID_rt != REG_ZERO) & (w_cnt[ID_rt] > CNT_W'(1));
        w_sp_haz  = ID_special & (w_special_cnt != '0);
        w_live    = ~Reset & ID_valid & ~ID_flush;
        w_issue   = w_live & (r_state == RUN) & ~(w_raw_a | w_raw_b | w_sp_haz);
        w_stall   = w_live & ~w_issue;
        w_wr_load = w_issue & ID_RegWrite & (ID_WriteRegister != REG_ZERO);
        w_sp_load = w_issue & ID_special;
        w_all_idle = (w_busy == '0) & ~w_special_busy;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic w_load;
        assign w_load = w_wr_load & (ID_WriteRegister == 5'(g));

        decode_hazard_scoreboard_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk      (Clk),
            .i_reset    (Reset),
            .i_load     (w_load),
            .i_load_val (CNT_W'(WB_LATENCY)),
            .o_cnt      (w_cnt[g]),
            .o_busy     (w_busy[g])
        );
    end

    decode_hazard_scoreboard_counter #(
        .CNT_W (CNT_W)
    ) u_special_cnt (
        .i_clk      (Clk),
        .i_reset    (Reset),
        .i_load     (w_sp_load),
        .i_load_val (CNT_W'(SPECIAL_LAT)),
        .o_cnt      (w_special_cnt),
        .o_busy     (w_special_busy)
    );

    // Drain FSM with registered drained flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= RUN;
            r_drained <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (drain_req) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        r_state <= RUN;
                    end else if (w_all_idle) begin
                        r_state   <= DRAINED;
                        r_drained <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        r_state   <= RUN;
                        r_drained <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RUN;
                    r_drained <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign ID_issue     = w_issue;
    assign ID_stall     = w_stall;
    assign busy_mask    = w_busy;
    assign special_busy = w_special_busy;
    assign drained      = r_drained;
    assign stall_count  = r_stall_count;

endmodule
